// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width constant for the 32-bit adder
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

endpackage : adder_pkg

// File: rtl/full_adder_1b.sv
// rtl/full_adder_1b.sv - single-bit full-adder cell
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the three-way parity; carry is the majority of the three inputs.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder_1b

// File: rtl/adder_32b.sv
// rtl/adder_32b.sv - 32-bit ripple-carry adder with registered result copy
module adder_32b
    import adder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    input  logic                   carry_in,
    output logic [ADDER_WIDTH-1:0] sum,
    output logic                   carry_out,
    output logic [ADDER_WIDTH-1:0] sum_q,
    output logic                   carry_out_q
);

    // carry[i] is the carry into cell i; carry[ADDER_WIDTH] leaves the top cell.
    logic [ADDER_WIDTH:0]   carry;
    logic [ADDER_WIDTH-1:0] sum_d;
    logic                   carry_out_d;

    assign carry[0] = carry_in;

    genvar i;
    generate
        for (i = 0; i < ADDER_WIDTH; i++) begin : g_cell
            full_adder_1b u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry[i]),
                .s    (sum[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    assign carry_out = carry[ADDER_WIDTH];

    // Next-state of the output registers is simply the live combinational result.
    always_comb begin
        sum_d       = sum;
        carry_out_d = carry_out;
    end

    // Capture the result each rising edge; reset clears the copy immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end

endmodule : adder_32b

// File: tb/tb_adder_32b.sv
// tb/tb_adder_32b.sv - directed, random and reset checks for adder_32b
module tb_adder_32b;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic [31:0] sum;
    logic        carry_out;
    logic [31:0] sum_q;
    logic        carry_out_q;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[10];

    adder_32b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .sum         (sum),
        .carry_out   (carry_out),
        .sum_q       (sum_q),
        .carry_out_q (carry_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at a falling edge, wait 10 units (one rising edge in between), then check both paths.
    task automatic apply_and_check(input string name, input logic [31:0] va, input logic [31:0] vb,
                                   input logic vc, input logic [31:0] es, input logic ec);
        @(negedge clk);
        a        = va;
        b        = vb;
        carry_in = vc;
        #10;
        check({name, "_comb"}, {carry_out, sum}, {ec, es});
        check({name, "_reg"}, {carry_out_q, sum_q}, {ec, es});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] ref33;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[1] = '{32'h00000001, 32'h00000006, 1'b0, 32'h00000007, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[8] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
        vecs[9] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};

        // Reset state: registers clear without any clock edge.
        rst_n    = 1'b0;
        a        = 32'h00000003;
        b        = 32'h00000004;
        carry_in = 1'b0;
        #1;
        check("reset_reg", {carry_out_q, sum_q}, 33'h0);
        check("reset_comb_live", {carry_out, sum}, {1'b0, 32'h00000007});
        @(posedge clk);
        #1;
        check("reset_hold", {carry_out_q, sum_q}, 33'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                            vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Random vectors against a 33-bit reference sum.
        for (int i = 0; i < 60; i++) begin
            ra    = $urandom;
            rb    = $urandom;
            rc    = 1'($urandom_range(0, 1));
            ref33 = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            apply_and_check($sformatf("rand%0d", i), ra, rb, rc, ref33[31:0], ref33[32]);
        end

        // Registered path has one edge of latency: change input, check old value before the edge.
        @(negedge clk);
        a        = 32'h00000010;
        b        = 32'h00000020;
        carry_in = 1'b0;
        @(posedge clk);
        #1;
        check("lat_capture", {carry_out_q, sum_q}, {1'b0, 32'h00000030});
        @(negedge clk);
        a = 32'h00000001;
        #1;
        check("lat_comb_new", {carry_out, sum}, {1'b0, 32'h00000021});
        check("lat_reg_old", {carry_out_q, sum_q}, {1'b0, 32'h00000030});

        // Mid-operation reset: registers clear between edges, combinational path unaffected.
        @(negedge clk);
        a        = 32'hFFFFFFFF;
        b        = 32'h00000001;
        carry_in = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_cout_q", {32'h0, carry_out_q}, 33'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_reg", {carry_out_q, sum_q}, 33'h0);
        check("rst_mid_comb", {carry_out, sum}, {1'b1, 32'h00000000});
        @(posedge clk);
        #1;
        check("rst_mid_hold", {carry_out_q, sum_q}, 33'h0);

        // First capture after release happens on the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_noedge", {carry_out_q, sum_q}, 33'h0);
        @(posedge clk);
        #1;
        check("rst_release_capture", {carry_out_q, sum_q}, {1'b1, 32'h00000000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder_32b
